// File: rtl/alu_muldiv_iter_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package alu_muldiv_iter_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Control-side decode of an M-extension instruction.
   function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
      return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
   endfunction

   function automatic logic op1_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic op2_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter_if.sv
// Request/response bundle between control and the multiply/divide unit.
interface alu_muldiv_iter_if #(parameter int XLEN = 32);
   logic            i_valid;
   logic            o_ready;
   logic [2:0]      i_funct3;
   logic [XLEN-1:0] i_op1;
   logic [XLEN-1:0] i_op2;
   logic            i_flush;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_result;

   modport master (
      output i_valid, i_funct3, i_op1, i_op2, i_flush, i_ready,
      input  o_ready, o_valid, o_result
   );

   modport slave (
      input  i_valid, i_funct3, i_op1, i_op2, i_flush, i_ready,
      output o_ready, o_valid, o_result
   );
endinterface

// File: rtl/alu_muldiv_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module alu_muldiv_iter_step #(
   parameter int XLEN = 32
) (
   input  logic              i_div,
   input  logic [2*XLEN-1:0] i_acc,
   input  logic [XLEN-1:0]   i_opd,
   output logic [2*XLEN-1:0] o_acc,
   output logic              o_q_bit
);

   logic [XLEN:0] sum;
   logic [XLEN:0] part;
   logic [XLEN:0] trial;

   // Multiply: acc = {partial product, remaining multiplier bits}, LSB first.
   // Divide:   acc = {partial remainder, dividend bits / quotient bits}, MSB first.
   always_comb begin
      sum     = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opd} : '0);
      part    = i_acc[2*XLEN-1:XLEN-1];
      trial   = part - {1'b0, i_opd};
      o_q_bit = i_div & ~trial[XLEN];
      if (i_div) begin
         o_acc = {(trial[XLEN] ? part[XLEN-1:0] : trial[XLEN-1:0]), i_acc[XLEN-2:0], 1'b0};
      end else begin
         o_acc = {sum, i_acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide execute unit with valid/ready handshake and flush.
module alu_muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   alu_muldiv_iter_if.slave      bus
);
   import alu_muldiv_iter_pkg::*;

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          f3_q, f3_d;
   logic                neg_q, neg_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opd_q, opd_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                s1, s2, div_zero, div_ovf, step_q_bit;
   logic [XLEN-1:0]     abs1, abs2, quo_rem;
   logic [2*XLEN-1:0]   prod, step_acc;

   alu_muldiv_iter_step #(.XLEN(XLEN)) u_step (
      .i_div   (f3_q[2]),
      .i_acc   (acc_q),
      .i_opd   (opd_q),
      .o_acc   (step_acc),
      .o_q_bit (step_q_bit)
   );

   assign bus.o_ready  = (state_q == ST_IDLE);
   assign bus.o_valid  = (state_q == ST_DONE);
   assign bus.o_result = result_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      result_d = result_q;

      s1       = op1_signed(bus.i_funct3) & bus.i_op1[XLEN-1];
      s2       = op2_signed(bus.i_funct3) & bus.i_op2[XLEN-1];
      abs1     = s1 ? -bus.i_op1 : bus.i_op1;
      abs2     = s2 ? -bus.i_op2 : bus.i_op2;
      div_zero = (bus.i_op2 == '0);
      div_ovf  = ((bus.i_funct3 == F3_DIV) || (bus.i_funct3 == F3_REM)) &&
                 (bus.i_op1 == MOST_NEG) && (bus.i_op2 == '1);

      // Sign fix must apply to the full double-width product before the high word is taken.
      prod     = neg_q ? -acc_q : acc_q;
      quo_rem  = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];

      if (bus.i_flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.i_valid) begin
                  f3_d = bus.i_funct3;
                  if (bus.i_funct3[2] && div_zero) begin
                     result_d = bus.i_funct3[1] ? bus.i_op1 : '1;
                     state_d  = ST_DONE;
                  end else if (div_ovf) begin
                     result_d = bus.i_funct3[1] ? '0 : bus.i_op1;
                     state_d  = ST_DONE;
                  end else if (bus.i_funct3[2]) begin
                     acc_d   = {{XLEN{1'b0}}, abs1};
                     opd_d   = abs2;
                     neg_d   = bus.i_funct3[1] ? s1 : (s1 ^ s2);
                     cnt_d   = CNT_W'(XLEN);
                     state_d = ST_CALC;
                  end else begin
                     acc_d   = {{XLEN{1'b0}}, abs2};
                     opd_d   = abs1;
                     neg_d   = s1 ^ s2;
                     cnt_d   = CNT_W'(XLEN);
                     state_d = ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc_d = {step_acc[2*XLEN-1:1], step_acc[0] | step_q_bit};
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_FIXUP;
               end
            end
            ST_FIXUP: begin
               if (!f3_q[2]) begin
                  result_d = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
               end else begin
                  result_d = neg_q ? -quo_rem : quo_rem;
               end
               state_d = ST_DONE;
            end
            ST_DONE: begin
               if (bus.i_ready) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         opd_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Self-checking bench for alu_muldiv_iter against a plain-arithmetic RV32M model.
module tb_alu_muldiv_iter;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_muldiv_iter_if #(.XLEN(XLEN)) bus ();

   alu_muldiv_iter #(.XLEN(XLEN)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      p  = '0;
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f3[2] && b == 32'd0) return 0;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return XLEN + 1;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'd1;
         4:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!bus.o_ready && n < 200) begin
         tick();
         n++;
      end
      check("idle_before_issue", 64'(bus.o_ready), 64'd1);
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      logic [31:0] exp;
      int          lat;
      logic        busy_ok;
      exp = ref_model(f3, a, b);
      wait_idle();
      bus.i_valid  = 1'b1;
      bus.i_funct3 = f3;
      bus.i_op1    = a;
      bus.i_op2    = b;
      tick();
      bus.i_valid = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      while (!bus.o_valid && lat < 3 * XLEN) begin
         if (bus.o_ready) busy_ok = 1'b0;
         bus.i_valid  = 1'($urandom_range(0, 1));
         bus.i_funct3 = 3'($urandom);
         bus.i_op1    = $urandom;
         bus.i_op2    = $urandom;
         tick();
         lat++;
      end
      bus.i_valid = 1'b0;
      check("latency", 64'(lat), 64'(ref_latency(f3, a, b)));
      check("ready_low_while_busy", 64'(busy_ok), 64'd1);
      check("result", 64'(bus.o_result), 64'(exp));
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", 64'(bus.o_valid), 64'd1);
         check("hold_result", 64'(bus.o_result), 64'(exp));
      end
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      check("valid_dropped", 64'(bus.o_valid), 64'd0);
      check("ready_after_handoff", 64'(bus.o_ready), 64'd1);
   endtask

   task automatic abort_divu(input logic use_rst);
      wait_idle();
      bus.i_valid  = 1'b1;
      bus.i_funct3 = 3'd5;
      bus.i_op1    = 32'd123456;
      bus.i_op2    = 32'd7;
      tick();
      bus.i_valid = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      if (use_rst) rst = 1'b1;
      else bus.i_flush = 1'b1;
      tick();
      rst         = 1'b0;
      bus.i_flush = 1'b0;
      check(use_rst ? "rst_abort_ready" : "flush_abort_ready", 64'(bus.o_ready), 64'd1);
      check(use_rst ? "rst_abort_valid" : "flush_abort_valid", 64'(bus.o_valid), 64'd0);
      if (use_rst) check("rst_abort_result", 64'(bus.o_result), 64'd0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.i_valid  = 1'b0;
      bus.i_funct3 = '0;
      bus.i_op1    = '0;
      bus.i_op2    = '0;
      bus.i_flush  = 1'b0;
      bus.i_ready  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_ready", 64'(bus.o_ready), 64'd1);
      check("reset_valid", 64'(bus.o_valid), 64'd0);
      check("reset_result", 64'(bus.o_result), 64'd0);

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'd5, 32'd100, 32'd7, 0);
      run_op(3'd7, 32'd100, 32'd7, 0);
      run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 0);
      run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 0);
      run_op(3'd4, 32'd5, 32'd0, 0);
      run_op(3'd6, 32'd5, 32'd0, 0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 10);

      abort_divu(1'b0);
      run_op(3'd4, 32'hFFFF_FC18, 32'd33, 0);
      abort_divu(1'b1);
      run_op(3'd2, 32'h8000_0001, 32'hC000_0000, 0);

      // flush must win over a same-cycle request
      wait_idle();
      bus.i_valid  = 1'b1;
      bus.i_flush  = 1'b1;
      bus.i_funct3 = 3'd0;
      bus.i_op1    = 32'd3;
      bus.i_op2    = 32'd4;
      tick();
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
      check("flush_over_accept_ready", 64'(bus.o_ready), 64'd1);
      check("flush_over_accept_valid", 64'(bus.o_valid), 64'd0);

      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom), pick_operand(), pick_operand(), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_muldiv_iter.md
Name: alu_muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at width XLEN.
- Sits beside the combinational alu as a second execute resource.
- Control steers M-extension instructions here and stalls on the valid/ready handshake until the result returns.
- Radix-2 shift-add multiply and restoring divide: one bit per cycle, with RISC-V-exact corner-case results.

Parameters:
- XLEN, 32, operand/result width; any even value >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit idle, can accept a request.
- i_funct3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_op1  input  XLEN  rs1 value (multiplicand/dividend).
- i_op2  input  XLEN  rs2 value (multiplier/divisor).
- i_flush  input  1  abort any in-flight operation (pipeline kill).
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_result  output  XLEN  result.

Behaviour:
- One clock domain (i_clk); reset synchronous, active-high (i_rst).
- Reset values:
  - state=IDLE, o_ready=1, o_valid=0, o_result=0.
  - Counter and internal accumulators = 0.
- States: IDLE, CALC, FIXUP, DONE. o_ready = (state==IDLE), combinational from state only.
- Accept: i_valid && o_ready && !i_flush at edge A.
  - Operands and funct3 are captured at edge A.
  - Inputs are ignored at all other times.
- Signedness at accept:
  - op1 is signed for MULH, MULHSU, DIV, REM.
  - op2 is signed for MULH, DIV, REM.
  - Absolute values are stored, plus a negate-result flag:
    - MUL-family: sign1 XOR sign2.
    - DIV: sign1 XOR sign2.
    - REM: sign1.
  - MUL low word is sign-agnostic: treat as unsigned.
- Special cases, resolved at accept (IDLE->DONE directly, o_valid high after edge A):
  - Divisor==0:
    - DIV/DIVU result = all-ones.
    - REM/REMU result = op1.
  - DIV with op1 = most-negative and op2 = -1: result = op1.
  - REM with op1 = most-negative and op2 = -1: result = 0.
- Normal path:
  - IDLE->CALC at A, counter loaded with XLEN.
  - CALC performs one iteration per edge (2*XLEN-bit product shift-add, or restoring quotient/remainder bit), decrementing the counter.
  - At counter==1, CALC->FIXUP.
  - FIXUP selects the low or high product word (or quotient/remainder), applies two's-complement negation if flagged, registers o_result, then ->DONE.
  - o_valid first high after edge A+XLEN+1 (33 edges for XLEN=32).
- DONE:
  - o_valid=1; o_result is held stable until handshake.
  - With i_ready=1 at an edge: ->IDLE, o_valid=0.
  - No accept in the same cycle as result handoff (o_ready=0 in DONE).
- Width rules:
  - All arithmetic is modulo 2^XLEN on results; product accumulator is 2*XLEN bits.
  - The divide partial remainder is XLEN+1 bits to hold the trial-subtract borrow.
- i_flush:
  - In any state, next edge -> IDLE, o_valid=0, counter cleared.
  - o_result keeps its last value (don't-care).
  - Flush has priority over accept and over handshake.
- i_rst mid-operation: identical to flush plus o_result cleared. i_rst has priority over all.

Decomposition:
- Shared package alu_pkg:
  - funct3 localparams for the eight M operations.
  - State encoding (2-bit enum IDLE=0, CALC=1, FIXUP=2, DONE=3).
  - RV32M opcode/funct7 constants (0110011 / 0000001) for control decode.
- One natural sub-module, muldiv_step:
  - Purely combinational single iteration, taking the mode bit, accumulator and operand, and producing the next accumulator and quotient bit.
  - The top keeps the FSM, counter, sign handling and handshake.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD -> o_result=0xFFFFFFEB; o_valid first high 33 edges after accept; o_ready=0 throughout.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIV -100/7 -> 0xFFFFFFF2 (-14); REM -100/7 -> 0xFFFFFFFE (-2).
- Corner-case latency:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
  - Each: o_valid high the cycle after accept.
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_result stable. Drop on the first edge with i_ready=1; o_ready=1 the next cycle.
- Aborts:
  - Assert i_flush at iteration 12 of DIVU -> IDLE next edge, no o_valid.
  - Repeat with i_rst -> o_result=0.
  - A new request issued immediately after either abort completes correctly.
